// File: rtl/dbg_access_arbiter_pkg.sv
// Shared definitions for the or1300 debug SPR access arbiter.
// Holds FSM encoding, requester indices, SPR indices, the latched access
// payload and a saturating counter helper.
package dbg_access_arbiter_pkg;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned TMO_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_STROBE = 3'd2,
    ST_DONE   = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_MON  = 1'b1;

  localparam logic [ADDR_W-1:0] SPR_NPC  = 16'h0010;
  localparam logic [ADDR_W-1:0] SPR_DSR  = 16'h3014;
  localparam logic [ADDR_W-1:0] SPR_DRR  = 16'h3015;
  localparam logic [ADDR_W-1:0] SPR_DMR1 = 16'h3010;

  // Access captured at grant time and replayed during the strobe.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } spr_access_t;

  function automatic logic [SETTLE_W-1:0] settle_inc(input logic [SETTLE_W-1:0] v);
    return (v == '1) ? v : v + SETTLE_W'(1);
  endfunction

endpackage

// File: rtl/dbg_rr_arbiter2.sv
// Two-way round-robin grant.
// Ports: clk/rst_n, req (per-requester request), accept (grant taken this
// cycle), gnt_idx_c/gnt_valid_c (combinational grant).
// The pointer names the favoured requester and moves to the other one after
// every accepted grant.
module dbg_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_idx_c,
  output logic       gnt_valid_c
);

  logic ptr;

  // Pointer side wins a tie; otherwise whoever is requesting.
  always_comb begin
    gnt_valid_c = |req;
    gnt_idx_c   = ptr;
    if (!req[ptr]) gnt_idx_c = ~ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ptr <= 1'b0;
    else if (accept && gnt_valid_c)  ptr <= ~gnt_idx_c;
  end

endmodule

// File: rtl/dbg_access_arbiter.sv
// Sequencer/arbiter for the or1300 external debug SPR port.
// Ports: clock/reset (async active-low); reqValid/reqWe/reqAddr/reqWData,
// holdStall, resume from the two requesters (0 = host, 1 = monitor);
// reqDone/reqError/reqRData/cpuHalted back to them; dbg_* to the debug unit.
// Flow: stall core, wait for settle, strobe one SPR access, report, one gap.
module dbg_access_arbiter
  import dbg_access_arbiter_pkg::*;
#(
  parameter int unsigned stallSettleCycles = 2,
  parameter int unsigned timeoutCycles     = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          reqValid,
  input  logic [NUM_REQ-1:0]          reqWe,
  input  logic [NUM_REQ*ADDR_W-1:0]   reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0]   reqWData,
  input  logic [NUM_REQ-1:0]          holdStall,
  input  logic [NUM_REQ-1:0]          resume,
  output logic [NUM_REQ-1:0]          reqDone,
  output logic                        reqError,
  output logic [DATA_W-1:0]           reqRData,
  output logic                        cpuHalted,
  output logic                        dbg_stall_o,
  output logic                        dbg_stb_o,
  output logic                        dbg_we_o,
  output logic [ADDR_W-1:0]           dbg_adr_o,
  output logic [DATA_W-1:0]           dbg_dat_o,
  input  logic                        dbg_ack_i,
  input  logic [DATA_W-1:0]           dbg_dat_i,
  input  logic                        dbg_bp_i
);

  localparam logic [SETTLE_W-1:0] SETTLE_TGT = SETTLE_W'(stallSettleCycles);
  localparam logic [TMO_W-1:0]    TMO_TGT    = TMO_W'(timeoutCycles);

  state_e                state, state_n;
  logic                  gnt, gnt_n;
  spr_access_t           cur, cur_n;
  logic [SETTLE_W-1:0]   settle_cnt, settle_cnt_n;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_n;
  logic [NUM_REQ-1:0]    done_n;
  logic                  err_n;
  logic [DATA_W-1:0]     rdata_n;
  logic                  halted_n, stall_n, stb_n, we_n;
  logic                  arb_idx_c, arb_valid_c, accept_c;

  dbg_rr_arbiter2 u_arb (
    .clk         (clock),
    .rst_n       (reset),
    .req         (reqValid),
    .accept      (accept_c),
    .gnt_idx_c   (arb_idx_c),
    .gnt_valid_c (arb_valid_c)
  );

  // The latch doubles as the address/data output register; it only changes
  // at grant, so write data is stable for the whole strobe.
  assign dbg_adr_o = cur.adr;
  assign dbg_dat_o = cur.dat;

  // Next state, next register values for all outputs.
  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    cur_n        = cur;
    tmo_cnt_n    = tmo_cnt;
    done_n       = '0;
    err_n        = 1'b0;
    rdata_n      = '0;
    accept_c     = 1'b0;
    // Counts cycles with stall already high, including the current one.
    settle_cnt_n = dbg_stall_o ? settle_inc(settle_cnt) : '0;
    // Breakpoint set dominates a simultaneous resume.
    halted_n     = dbg_bp_i | (cpuHalted & ~(|resume));

    unique case (state)
      ST_IDLE: begin
        if (arb_valid_c) begin
          accept_c  = 1'b1;
          gnt_n     = arb_idx_c;
          cur_n.we  = reqWe[arb_idx_c];
          cur_n.adr = arb_idx_c ? reqAddr[2*ADDR_W-1:ADDR_W] : reqAddr[ADDR_W-1:0];
          cur_n.dat = arb_idx_c ? reqWData[2*DATA_W-1:DATA_W] : reqWData[DATA_W-1:0];
          state_n   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmo_cnt_n = '0;
        if (settle_cnt_n >= SETTLE_TGT) state_n = ST_STROBE;
      end
      ST_STROBE: begin
        tmo_cnt_n = tmo_cnt + TMO_W'(1);
        if (dbg_ack_i) begin
          state_n = ST_DONE;
          done_n  = gnt ? 2'b10 : 2'b01;
          rdata_n = cur.we ? '0 : dbg_dat_i;
        end else if (tmo_cnt_n >= TMO_TGT) begin
          state_n = ST_DONE;
          done_n  = gnt ? 2'b10 : 2'b01;
          err_n   = 1'b1;
        end
      end
      ST_DONE: state_n = ST_GAP;
      ST_GAP:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    stall_n = (state_n != ST_IDLE) | (|holdStall) | halted_n;
    stb_n   = (state_n == ST_STROBE);
    we_n    = stb_n & cur_n.we;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      gnt         <= 1'b0;
      cur         <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      reqDone     <= '0;
      reqError    <= 1'b0;
      reqRData    <= '0;
      cpuHalted   <= 1'b0;
      dbg_stall_o <= 1'b0;
      dbg_stb_o   <= 1'b0;
      dbg_we_o    <= 1'b0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      cur         <= cur_n;
      settle_cnt  <= settle_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      reqDone     <= done_n;
      reqError    <= err_n;
      reqRData    <= rdata_n;
      cpuHalted   <= halted_n;
      dbg_stall_o <= stall_n;
      dbg_stb_o   <= stb_n;
      dbg_we_o    <= we_n;
    end
  end

endmodule

// File: tb/tb_dbg_access_arbiter.sv
// Directed bench for dbg_access_arbiter with a scoreboard of completions and
// a small debug-unit model (ack two cycles after the strobe is first seen).
module tb_dbg_access_arbiter;
  import dbg_access_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  reqValid = '0, reqWe = '0, holdStall = '0, resume = '0;
  logic [31:0] reqAddr = '0;
  logic [63:0] reqWData = '0;
  logic [1:0]  reqDone;
  logic        reqError, cpuHalted;
  logic [31:0] reqRData;
  logic        dbg_stall_o, dbg_stb_o, dbg_we_o;
  logic [15:0] dbg_adr_o;
  logic [31:0] dbg_dat_o;
  logic        dbg_ack_i = 1'b0;
  logic [31:0] dbg_dat_i = '0;
  logic        dbg_bp_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    bit          cmp_rdata;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [31:0] spr [logic [15:0]];
  bit          ack_en = 1'b1;
  int          stb_cnt = 0;

  dbg_access_arbiter #(.stallSettleCycles(2), .timeoutCycles(4)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqWe(reqWe),
    .reqAddr(reqAddr), .reqWData(reqWData), .holdStall(holdStall),
    .resume(resume), .reqDone(reqDone), .reqError(reqError),
    .reqRData(reqRData), .cpuHalted(cpuHalted), .dbg_stall_o(dbg_stall_o),
    .dbg_stb_o(dbg_stb_o), .dbg_we_o(dbg_we_o), .dbg_adr_o(dbg_adr_o),
    .dbg_dat_o(dbg_dat_o), .dbg_ack_i(dbg_ack_i), .dbg_dat_i(dbg_dat_i),
    .dbg_bp_i(dbg_bp_i)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Debug unit model: ack in the third strobe cycle, SPR storage.
  always @(posedge clock) begin
    stb_cnt   <= dbg_stb_o ? stb_cnt + 1 : 0;
    dbg_ack_i <= ack_en && dbg_stb_o && (stb_cnt == 1);
    if (ack_en && dbg_stb_o && (stb_cnt == 1)) begin
      if (dbg_we_o) spr[dbg_adr_o] = dbg_dat_o;
      else dbg_dat_i <= spr.exists(dbg_adr_o) ? spr[dbg_adr_o] : 32'h0BAD_0000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completion scoreboard.
  always @(negedge clock) begin
    if (reset && reqDone != 2'b00) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 32'(reqDone), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_idx", 32'(reqDone), 32'(mon_e.done));
        chk("done_err", 32'(reqError), 32'(mon_e.err));
        if (mon_e.cmp_rdata) chk("done_rdata", reqRData, mon_e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic e, input logic [31:0] r, input bit c);
    exp_t x;
    x.done = d; x.err = e; x.rdata = r; x.cmp_rdata = c;
    sb_q.push_back(x);
  endtask

  // One access from one requester; reports issue, first-strobe and done cycles.
  task automatic do_req(input int idx, input logic we, input logic [15:0] adr,
                        input logic [31:0] dat, input logic err, input logic [31:0] rd,
                        input bit want_stall, output int t_issue, output int t_rise,
                        output int t_done, output int nstb);
    logic prev = 1'b0;
    t_rise = -1; t_done = -1; nstb = 0;
    reqWe[idx] = we;
    reqAddr[idx*16 +: 16] = adr;
    reqWData[idx*32 +: 32] = dat;
    reqValid[idx] = 1'b1;
    push(idx == 0 ? 2'b01 : 2'b10, err, rd, !we);
    t_issue = cyc;
    for (int i = 0; i < 60; i++) begin
      step();
      if (want_stall) chk("stall_held", 32'(dbg_stall_o), 32'd1);
      if (dbg_stb_o) nstb++;
      if (dbg_stb_o && !prev && t_rise < 0) t_rise = cyc;
      prev = dbg_stb_o;
      if (reqDone[idx]) begin
        t_done = cyc;
        reqValid[idx] = 1'b0;
        break;
      end
    end
    if (t_done < 0) chk("req_wait_expired", 32'd0, 32'd1);
  endtask

  // Host write NPC and monitor read DRR requested in the same cycle.
  task automatic run_both(input string tag);
    logic prev = 1'b0;
    int d0 = -1, d1 = -1, r0 = -1, r1 = -1, nrise = 0;
    reqWe = 2'b01;
    reqAddr = {SPR_DRR, SPR_NPC};
    reqWData = {32'h0, 32'h0000_0100};
    reqValid = 2'b11;
    push(2'b01, 1'b0, 32'h0, 1'b0);
    push(2'b10, 1'b0, 32'h0000_0008, 1'b1);
    for (int i = 0; i < 80; i++) begin
      step();
      if (dbg_stb_o && !prev) begin
        nrise++;
        if (nrise == 1) r0 = cyc; else r1 = cyc;
      end
      if (dbg_stb_o && dbg_we_o) begin
        chk({tag, "_wdata_stable"}, dbg_dat_o, 32'h0000_0100);
        chk({tag, "_wadr"}, 32'(dbg_adr_o), 32'(SPR_NPC));
      end
      prev = dbg_stb_o;
      if (reqDone[0]) begin d0 = cyc; reqValid[0] = 1'b0; end
      if (reqDone[1]) begin d1 = cyc; reqValid[1] = 1'b0; end
      if (d0 >= 0 && d1 >= 0) break;
    end
    chk({tag, "_both_done"}, 32'(d0 >= 0 && d1 >= 0), 32'd1);
    chk({tag, "_host_first"}, 32'(d0 < d1), 32'd1);
    chk({tag, "_two_strobes"}, 32'(nrise), 32'd2);
    chk({tag, "_mon_after_gap"}, 32'(r1 >= d0 + 2), 32'd1);
    chk({tag, "_first_strobe_before_host_done"}, 32'(r0 < d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti, tr, td, ns, t;
    spr[SPR_DSR]  = 32'h0000_2000;
    spr[SPR_DRR]  = 32'h0000_0008;
    spr[SPR_DMR1] = 32'h0;

    step(); step();
    chk("rst_stall", 32'(dbg_stall_o), 32'd0);
    chk("rst_stb", 32'(dbg_stb_o), 32'd0);
    chk("rst_we", 32'(dbg_we_o), 32'd0);
    chk("rst_done", 32'(reqDone), 32'd0);
    chk("rst_err", 32'(reqError), 32'd0);
    chk("rst_halted", 32'(cpuHalted), 32'd0);
    chk("rst_adr", 32'(dbg_adr_o), 32'd0);
    chk("rst_dat", dbg_dat_o, 32'd0);
    chk("rst_rdata", reqRData, 32'd0);
    reset = 1'b1;
    step(); step();

    // Simultaneous requests right after reset: pointer 0 favours the host.
    run_both("sim");
    step(); step(); step();
    do_req(0, 1'b0, SPR_NPC, 32'h0, 1'b0, 32'h0000_0100, 1'b0, ti, tr, td, ns);
    step(); step(); step();

    // Exact timing of a host DSR read from an unstalled idle core.
    reqWe[0] = 1'b0;
    reqAddr[15:0] = SPR_DSR;
    reqValid[0] = 1'b1;
    push(2'b01, 1'b0, 32'h0000_2000, 1'b1);
    t = cyc;
    step(); chk("t1_stall", 32'(dbg_stall_o), 32'd1); chk("t1_stb", 32'(dbg_stb_o), 32'd0);
    step(); chk("t2_stb", 32'(dbg_stb_o), 32'd0);
    step(); chk("t3_stb", 32'(dbg_stb_o), 32'd1); chk("t3_adr", 32'(dbg_adr_o), 32'(SPR_DSR));
    chk("t3_we", 32'(dbg_we_o), 32'd0);
    step(); chk("t4_stb", 32'(dbg_stb_o), 32'd1);
    step(); chk("t5_stb", 32'(dbg_stb_o), 32'd1);
    step(); chk("t6_done", 32'(reqDone), 32'd1); chk("t6_stb", 32'(dbg_stb_o), 32'd0);
    chk("t6_rdata", reqRData, 32'h0000_2000);
    chk("t6_cycle", 32'(cyc - t), 32'd6);
    reqValid[0] = 1'b0;
    step(); chk("t7_stall", 32'(dbg_stall_o), 32'd1); chk("t7_stb", 32'(dbg_stb_o), 32'd0);
    step(); chk("t8_stall", 32'(dbg_stall_o), 32'd0);
    step(); step();

    // Timeout with ack withheld, then a normal access.
    ack_en = 1'b0;
    do_req(0, 1'b0, SPR_DSR, 32'h0, 1'b1, 32'h0, 1'b0, ti, tr, td, ns);
    chk("tmo_stb_cycles", 32'(ns), 32'd4);
    chk("tmo_rdata_zero", reqRData, 32'd0);
    ack_en = 1'b1;
    step(); step(); step();
    do_req(1, 1'b0, SPR_DSR, 32'h0, 1'b0, 32'h0000_2000, 1'b0, ti, tr, td, ns);
    chk("post_tmo_stb_cycles", 32'(ns), 32'd3);
    chk("post_tmo_latency", 32'(td - ti), 32'd6);
    step(); step(); step();

    // Breakpoint halt and resume.
    dbg_bp_i = 1'b1; step(); dbg_bp_i = 1'b0;
    chk("bp_halted", 32'(cpuHalted), 32'd1);
    chk("bp_stall", 32'(dbg_stall_o), 32'd1);
    do_req(0, 1'b0, SPR_DSR, 32'h0, 1'b0, 32'h0000_2000, 1'b1, ti, tr, td, ns);
    step(); step(); step(); step();
    chk("bp_stall_after", 32'(dbg_stall_o), 32'd1);
    dbg_bp_i = 1'b1; resume = 2'b01; step(); dbg_bp_i = 1'b0; resume = 2'b00;
    chk("bp_resume_same_cycle", 32'(cpuHalted), 32'd1);
    step();
    chk("bp_stall_before_resume", 32'(dbg_stall_o), 32'd1);
    resume = 2'b10; step(); resume = 2'b00;
    chk("resume_clears", 32'(cpuHalted), 32'd0);
    chk("resume_stall_drop", 32'(dbg_stall_o), 32'd0);
    step(); step();

    // Held stall: one-cycle settle, back-to-back accesses, no stall drop.
    holdStall = 2'b10;
    step(); step(); step();
    do_req(0, 1'b0, SPR_DSR, 32'h0, 1'b0, 32'h0000_2000, 1'b1, ti, tr, td, ns);
    chk("hold_settle_one", 32'(tr - ti), 32'd2);
    for (int k = 0; k < 2; k++) begin
      do_req(0, 1'b0, SPR_DRR, 32'h0, 1'b0, 32'h0000_0008, 1'b1, ti, tr, td, ns);
      chk("hold_b2b_strobe", 32'(tr - ti), 32'd4);
    end
    holdStall = 2'b00;
    step();
    chk("hold_gap_stall", 32'(dbg_stall_o), 32'd1);
    step();
    chk("hold_release_stall", 32'(dbg_stall_o), 32'd0);
    step();

    // Reset during strobe (pointer now favours the monitor).
    reqWe[0] = 1'b0;
    reqAddr[15:0] = SPR_DSR;
    reqValid[0] = 1'b1;
    push(2'b01, 1'b0, 32'h0000_2000, 1'b1);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dbg_stb_o) begin t = cyc; break; end
    end
    chk("rst_mid_reached_strobe", 32'(t >= 0), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_stb", 32'(dbg_stb_o), 32'd0);
    chk("rst_mid_stall", 32'(dbg_stall_o), 32'd0);
    chk("rst_mid_done", 32'(reqDone), 32'd0);
    sb_q.delete();
    reqValid = 2'b00;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_stall", 32'(dbg_stall_o), 32'd0);
    run_both("post_rst");
    step(); step(); step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
